// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - configuration request port bundle for clk_en_gen
interface clk_en_gen_if #(
   parameter int CHW   = 2,
   parameter int ACC_W = 16
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CHW-1:0]   cfg_ch;
   logic [ACC_W-1:0] cfg_num;
   logic [ACC_W-1:0] cfg_den;
   logic             cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_num, cfg_den,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_num, cfg_den,
      output cfg_ready, cfg_err
   );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - rational clock-enable generator gated by a debounced PLL lock
module clk_en_gen #(
   parameter int NCH      = 4,
   parameter int ACC_W    = 16,
   parameter int LOCK_CYC = 1024,
   parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           resetn,
   input  logic           pll_lock,
   clk_en_gen_if.slave    cfg,
   output logic           ready,
   output logic [NCH-1:0] ce
);

   localparam int               CNT_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYC - 1);
   localparam logic [CHW:0]     NCH_C    = (CHW + 1)'(NCH);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      SETTLE,
      RUN
   } state_t;

   logic             lk_meta_q;
   logic             lk_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             cfg_ready_q;
   logic             cfg_err_q;
   logic [ACC_W-1:0] num_q [NCH];
   logic [ACC_W-1:0] den_q [NCH];
   logic [ACC_W-1:0] acc_q [NCH];
   logic [ACC_W-1:0] acc_d [NCH];
   logic [NCH-1:0]   ce_q;
   logic [NCH-1:0]   ce_d;
   logic [ACC_W:0]   nxt_w [NCH];

   logic xfer;
   logic ch_ok;
   logic run_step;

   // One accumulator step: returns {strobe, next accumulator}.
   function automatic logic [ACC_W:0] step_fn(
      input logic [ACC_W-1:0] acc,
      input logic [ACC_W-1:0] num,
      input logic [ACC_W-1:0] den
   );
      logic [ACC_W:0] s;
      logic [ACC_W:0] r;
      s = {1'b0, acc} + {1'b0, num};
      r = s - {1'b0, den};
      if (den == '0) begin
         step_fn = '0;
      end else if (num >= den) begin
         step_fn = {1'b1, {ACC_W{1'b0}}};
      end else if (s >= {1'b0, den}) begin
         step_fn = {1'b1, r[ACC_W-1:0]};
      end else begin
         step_fn = {1'b0, s[ACC_W-1:0]};
      end
   endfunction

   assign xfer     = cfg.cfg_valid && cfg_ready_q;
   assign ch_ok    = ({1'b0, cfg.cfg_ch} < NCH_C);
   assign run_step = (state_q == RUN) && lk_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lk_meta_q <= 1'b0;
         lk_q      <= 1'b0;
      end else begin
         lk_meta_q <= pll_lock;
         lk_q      <= lk_meta_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               cnt_q <= '0;
               if (lk_q) begin
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (!lk_q) begin
                  state_q <= WAIT_LOCK;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RUN: begin
               if (!lk_q) begin
                  state_q <= WAIT_LOCK;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= WAIT_LOCK;
               ready_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Ratio registers survive lock loss; only reset clears them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cfg_ready_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            num_q[i] <= '0;
            den_q[i] <= '0;
         end
      end else begin
         cfg_ready_q <= !xfer;
         cfg_err_q   <= xfer && !ch_ok;
         for (int i = 0; i < NCH; i++) begin
            if (xfer && ch_ok && (cfg.cfg_ch == CHW'(i))) begin
               num_q[i] <= cfg.cfg_num;
               den_q[i] <= cfg.cfg_den;
            end
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_step
      assign nxt_w[g] = run_step ? step_fn(acc_q[g], num_q[g], den_q[g]) : '0;
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         acc_d[i] = nxt_w[i][ACC_W-1:0];
         ce_d[i]  = nxt_w[i][ACC_W];
         if (xfer && ch_ok && (cfg.cfg_ch == CHW'(i))) begin
            acc_d[i] = '0;
            ce_d[i]  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ce_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         ce_q <= ce_d;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign ready         = ready_q;
   assign ce            = ce_q;
   assign cfg.cfg_ready = cfg_ready_q;
   assign cfg.cfg_err   = cfg_err_q;

endmodule
